aes_decrypt: RTL and testbench

- Iterative AES-256 decryption core: the inverse of the AES-256 encrypt datapath, sharing its ready/valid start-and-result interface and byte ordering.
- Takes a 128-bit ciphertext and a 256-bit key and returns the plaintext.
- Runs forward key expansion into a round-key store, then applies inverse rounds 14 down to 0, one round per clock.
- Sits beside the encrypt core in the AES subsystem for round-trip use.

---
 rtl/aes_pkg.sv | 105 ++++++++++
 rtl/aes_inv_round.sv | 20 ++
 rtl/aes_decrypt.sv | 154 +++++++++++++++
 tb/tb_aes_decrypt.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the AES-256 decrypt core.
// S-box values are derived algebraically (field inverse + affine map)
// rather than stored as lookup tables.
package aes_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYEXP = 3'd1,
      INIT   = 3'd2,
      ROUND  = 3'd3,
      FINAL  = 3'd4
   } state_t;

   // Byte k in FIPS-197 order sits at index 15-k.
   typedef logic [15:0][7:0] blk_t;

   localparam logic [7:0] RCON [0:7] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                         8'h08, 8'h10, 8'h20, 8'h40};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a12, a15, a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a12  = gmul(gmul(a3, a3), gmul(a3, a3));
      a15  = gmul(a12, a3);
      a240 = gmul(a15, a15);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      return gmul(gmul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      blk_t a;
      blk_t o;
      a = s;
      for (int k = 0; k < 16; k++) o[4'(k)] = inv_sbox(a[4'(k)]);
      return o;
   endfunction

   // Row r of column c takes the byte from column (c - r) mod 4.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      blk_t a;
      blk_t o;
      a = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[4'(15 - (4 * c + r))] = a[4'(15 - (4 * ((c - r + 4) % 4) + r))];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      blk_t a;
      blk_t o;
      logic [7:0] a0, a1, a2, a3;
      a = s;
      for (int c = 0; c < 4; c++) begin
         a0 = a[4'(15 - 4 * c)];
         a1 = a[4'(14 - 4 * c)];
         a2 = a[4'(13 - 4 * c)];
         a3 = a[4'(12 - 4 * c)];
         o[4'(15 - 4 * c)] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[4'(14 - 4 * c)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[4'(13 - 4 * c)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[4'(12 - 4 * c)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse AES round, purely combinational. The last round of the
// inverse cipher has no InvMixColumns, selected by is_final.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] st,
   input  logic [127:0] rk,
   input  logic         is_final,
   output logic [127:0] st_next
);

   logic [127:0] added;

   // InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns
   always_comb begin
      added   = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
      st_next = is_final ? added : inv_mix_columns(added);
   end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-256 decryption core: forward key expansion into a
// round-key store, then one inverse round per clock.
// Optional macro AES_DEC_KEY_CACHE_EN: reuse the expanded keys when the
// same key is presented again.
//
// state  | meaning
// IDLE   | waiting for ready; operands and rk0/rk1 latched on start
// KEYEXP | one round key per cycle, rk2..rk14
// INIT   | initial AddRoundKey with rk14
// ROUND  | inverse rounds 13..1
// FINAL  | inverse round 0 without InvMixColumns, result registered
module aes_decrypt
   import aes_pkg::*;
#(
   parameter int KEY_W = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ready,
   input  logic [127:0] data_in,
   input  logic [255:0] key,
   output logic [127:0] data_out,
   output logic         valid,
   output logic         busy
);

   localparam int NR = KEY_W / 32 + 6;

   generate
      if (KEY_W != 256) begin : g_key_w_chk
         $error("aes_decrypt: KEY_W must be 256");
      end
   endgenerate

   state_t       state, state_next;
   logic         start, hit;
   logic [3:0]   round, kidx;
   logic [127:0] ct_r, st, rk_new, round_out;
   logic [127:0] rk_store [0:NR];
   logic [31:0]  kt, w0, w1, w2, w3;
   logic [127:0] rk_prev2;

`ifdef AES_DEC_KEY_CACHE_EN
   logic         cache_valid;
   logic [255:0] key_r;

   assign hit = cache_valid && (key == key_r);

   // Cache is valid once a full expansion has completed for key_r
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         key_r       <= '0;
      end else begin
         if (start) key_r <= key;
         if (state == KEYEXP && state_next == INIT) cache_valid <= 1'b1;
      end
   end
`else
   assign hit = 1'b0;
`endif

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode; ready only matters in IDLE
   always_comb begin
      state_next = state;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (ready) begin
               start      = 1'b1;
               state_next = hit ? INIT : KEYEXP;
            end
         end
         KEYEXP:  if (kidx == 4'(NR)) state_next = INIT;
         INIT:    state_next = ROUND;
         ROUND:   if (round == 4'd1) state_next = FINAL;
         FINAL:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next round key: words 4*kidx..4*kidx+3 from rk[kidx-2] and the last word of rk[kidx-1]
   always_comb begin
      kt       = rk_store[kidx - 4'd1][31:0];
      rk_prev2 = rk_store[kidx - 4'd2];
      if (!kidx[0]) kt = sub_word({kt[23:0], kt[31:24]}) ^ {RCON[kidx[3:1]], 24'h0};
      else          kt = sub_word(kt);
      w0     = rk_prev2[127:96] ^ kt;
      w1     = rk_prev2[95:64]  ^ w0;
      w2     = rk_prev2[63:32]  ^ w1;
      w3     = rk_prev2[31:0]   ^ w2;
      rk_new = {w0, w1, w2, w3};
   end

   // Round-key store; contents are only meaningful after a start
   always_ff @(posedge clk) begin
      if (start) begin
         rk_store[0] <= key[255:128];
         rk_store[1] <= key[127:0];
      end else if (state == KEYEXP) begin
         rk_store[kidx] <= rk_new;
      end
   end

   // In FINAL round has reached 0, so rk_store[round] is rk0
   aes_inv_round u_inv_round (
      .st       (st),
      .rk       (rk_store[round]),
      .is_final (state == FINAL),
      .st_next  (round_out)
   );

   // Datapath registers and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ct_r     <= '0;
         st       <= '0;
         data_out <= '0;
         valid    <= 1'b0;
         round    <= '0;
         kidx     <= '0;
      end else begin
         valid <= (state == FINAL);
         case (state)
            IDLE: begin
               if (start) begin
                  ct_r <= data_in;
                  kidx <= 4'd2;
               end
            end
            KEYEXP: if (kidx != 4'(NR)) kidx <= kidx + 4'd1;
            INIT: begin
               st    <= ct_r ^ rk_store[NR];
               round <= 4'(NR - 1);
            end
            ROUND: begin
               st    <= round_out;
               round <= round - 4'd1;
            end
            FINAL:   data_out <= round_out;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed self-checking bench for aes_decrypt using FIPS-197 C.3 and
// SP800-38A F.1.6 vectors.
module tb_aes_decrypt;

   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] SP_CT  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
   localparam logic [127:0] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;

   localparam int LAT = 28;
`ifdef AES_DEC_KEY_CACHE_EN
   localparam int HIT_LAT = 15;
`else
   localparam int HIT_LAT = 28;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ready;
   logic [127:0] data_in;
   logic [255:0] key;
   logic [127:0] data_out;
   logic         valid;
   logic         busy;

   int           checks = 0;
   int           errors = 0;
   logic [127:0] prev_out;

   always #5 clk = ~clk;

   aes_decrypt dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .data_in  (data_in),
      .key      (key),
      .data_out (data_out),
      .valid    (valid),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a start on the next sampling edge, leave 1ns after that edge
   task automatic start_op(input logic [127:0] ct, input logic [255:0] k, input string tag);
      @(negedge clk);
      ready   = 1'b1;
      data_in = ct;
      key     = k;
      @(posedge clk);
      #1;
      ready = 1'b0;
      chk({tag, "_busy"}, {255'd0, busy}, 256'd1);
   endtask

   // Entered 1ns after the sampling edge; counts edges until valid
   task automatic wait_result(input logic [127:0] pt, input int lat, input string tag);
      int   n;
      logic hold_bad;
      n        = 0;
      hold_bad = 1'b0;
      while (valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (valid !== 1'b1 && data_out !== prev_out) hold_bad = 1'b1;
      end
      chk({tag, "_latency"}, 256'(n), 256'(lat));
      chk({tag, "_data"}, {128'd0, data_out}, {128'd0, pt});
      chk({tag, "_hold"}, {255'd0, hold_bad}, 256'd0);
      prev_out = pt;
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {255'd0, valid}, 256'd0);
   endtask

   initial begin
      int spurious;
      rst_n    = 1'b0;
      ready    = 1'b0;
      data_in  = '0;
      key      = '0;
      prev_out = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {255'd0, valid}, 256'd0);
      chk("rst_busy", {255'd0, busy}, 256'd0);
      chk("rst_data", {128'd0, data_out}, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", {255'd0, busy}, 256'd0);

      start_op(C3_CT, C3_KEY, "c3");
      wait_result(C3_PT, LAT, "c3");
      start_op(C3_CT, C3_KEY, "c3_again");
      wait_result(C3_PT, HIT_LAT, "c3_again");
      start_op(SP_CT, SP_KEY, "sp");
      wait_result(SP_PT, LAT, "sp");

      // ready held through a run while operands change; restart only in the valid cycle
      @(negedge clk);
      ready   = 1'b1;
      data_in = C3_CT;
      key     = C3_KEY;
      @(posedge clk);
      #1;
      data_in = SP_CT;
      key     = SP_KEY;
      wait_result(C3_PT, LAT, "held1");
      ready = 1'b0;
      chk("held_restart_busy", {255'd0, busy}, 256'd1);
      wait_result(SP_PT, LAT, "held2");

      // reset in the middle of ROUND
      start_op(SP_CT, SP_KEY, "abort");
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", {255'd0, valid}, 256'd0);
      chk("abort_busy", {255'd0, busy}, 256'd0);
      chk("abort_data", {128'd0, data_out}, 256'd0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      prev_out = '0;
      spurious = 0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk);
         #1;
         if (valid !== 1'b0 || busy !== 1'b0) spurious++;
      end
      chk("abort_no_activity", 256'(spurious), 256'd0);
      start_op(C3_CT, C3_KEY, "after_rst");
      wait_result(C3_PT, LAT, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
